// File: rtl/dmem_wbuf_pkg.sv
// Shared definitions for the data-memory write-buffer controller.
package dmem_wbuf_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned AW_DEF    = 32;
  localparam int unsigned DW_DEF    = 32;

  // Encodings match the legacy header values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_wbuf_if.sv
// Word-wide data-memory bus with a req/ack handshake.
interface dmem_wbuf_if
  import dmem_wbuf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dmem_wbuf_fifo.sv
// Circular posted-store buffer with a youngest-match forwarding search.
module dmem_wbuf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-3:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  input  logic [AW-3:0]            srch_addr_i,
  output logic [AW-3:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     hit_o,
  output logic [DW-1:0]            hit_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-3:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic [PW-1:0] idx;

  assign full_o      = (count_q == CW'(DEPTH));
  assign push_ok     = push_i & ~full_o;
  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == srch_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data-side memory controller: posted write buffer, load forwarding, stall generation.
module dmem_wbuf
  import dmem_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  dmem_wbuf_if.master   mem
);

  state_t                 state_q, state_d;
  logic [AW-3:0]          rd_addr_q, rd_addr_d;
  logic [AW-3:0]          head_addr;
  logic [DW-1:0]          head_data;
  logic [$clog2(DEPTH):0] cnt;
  logic                   full;
  logic                   hit;
  logic [DW-1:0]          hit_data;
  logic                   is_load;
  logic                   load_miss;
  logic                   pop;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];
  assign is_load         = memread & ~memwrite;
  assign load_miss       = is_load & ~hit;
  assign pop             = (state_q == WR) & mem.mem_ack;

  dmem_wbuf_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (memwrite),
    .push_addr_i(addr[AW-1:2]),
    .push_data_i(wdata),
    .pop_i      (pop),
    .srch_addr_i(addr[AW-1:2]),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .count_o    (cnt),
    .full_o     (full),
    .hit_o      (hit),
    .hit_data_o (hit_data)
  );

  // Transaction sequencing: a pending load miss beats draining.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d   = RD;
          rd_addr_d = addr[AW-1:2];
        end else if (cnt != '0) begin
          state_d = WR;
        end
      end
      WR:      if (mem.mem_ack) state_d = IDLE;
      RD:      if (mem.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched read address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Memory port driven purely from state so reset drops the request immediately.
  always_comb begin
    mem.mem_req   = (state_q != IDLE);
    mem.mem_we    = (state_q == WR);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_q == WR) begin
      mem.mem_addr  = {head_addr, 2'b00};
      mem.mem_wdata = head_data;
    end else if (state_q == RD) begin
      mem.mem_addr  = {rd_addr_q, 2'b00};
    end
  end

  // Core-facing load data and stall; a full-buffer store stays stalled through the ack cycle.
  always_comb begin
    stall = 1'b0;
    rdata = '0;
    if (reset) begin
      if (memwrite) begin
        stall = full;
      end else if (memread) begin
        if (hit) begin
          rdata = hit_data;
        end else if (state_q == RD) begin
          stall = ~mem.mem_ack;
          rdata = mem.mem_rdata;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule
